// File: rtl/definitions_pkg.sv
// Shared opcode, state and datapath-select encodings for the multicycle RV32I core.
// state_ctrl() maps each sequencer state to its state-only datapath selects.
package definitions_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_UPIMM,
        S_ALUWB,
        S_JAL,
        S_JALR,
        S_LINK,
        S_BRANCH,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        reg_write;
        logic        branch;
        alu_src_a_e  src_a;
        alu_src_b_e  src_b;
        alu_op_e     alu_op;
        result_src_e result_src;
    } ctrl_t;

    // The opcode only matters for UPIMM, where LUI adds to zero and AUIPC to the old PC.
    function automatic ctrl_t state_ctrl(input state_e st, input opcode_e op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.src_a      = SRCA_PC;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.src_a = SRCA_OLDPC;
                c.src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.src_a = SRCA_RS1;
                c.src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                c.src_a  = SRCA_RS1;
                c.src_b  = SRCB_RS2;
                c.alu_op = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                c.src_a  = SRCA_RS1;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALUOP_FUNCT;
            end
            S_UPIMM: begin
                c.src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                c.src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_JAL: begin
                c.src_a      = SRCA_OLDPC;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
            end
            S_JALR: begin
                c.src_a      = SRCA_RS1;
                c.src_b      = SRCB_IMM;
                c.result_src = RES_ALU;
            end
            S_LINK: begin
                c.src_a      = SRCA_OLDPC;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.src_a      = SRCA_RS1;
                c.src_b      = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_branch_resolve.sv
// Branch-taken decision from funct3 and the ALU compare flags.
// The signed/unsigned distinction is already folded into less_than_i by the ALU.
module branch_resolve (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       less_than_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            3'b000:          taken_o = zero_i;
            3'b001:          taken_o = !zero_i;
            3'b100, 3'b110:  taken_o = less_than_i;
            3'b101, 3'b111:  taken_o = !less_than_i;
            default:         taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: walks each instruction through fetch/decode/execute/
// memory/writeback, stalls on mem_ready_i, traps illegal opcodes and counts retirements.
module mc_control_fsm
    import definitions_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  opcode_e          op_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             less_than_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       result_src_o,
    output logic             branch_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o,
    output state_e           state_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;
    logic             taken;
    logic             retire;

    branch_resolve u_branch_resolve (
        .funct3_i    (funct3_i),
        .zero_i      (zero_i),
        .less_than_i (less_than_i),
        .taken_o     (taken)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPIMM;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_UPIMM, S_JAL: state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_MEMWB, S_ALUWB, S_LINK, S_BRANCH: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Every path back into FETCH ends an instruction; TRAP never returns there.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    // Selects are precomputed from the next state so they come straight out of flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH, OP_LOAD);
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, op_i);
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_ONE;
            end
        end
    end

    // Strobes that would start a memory or PC/IR update are held off during reset.
    assign mem_req_o  = ctrl_q.mem_req & rst_ni;
    assign ir_write_o = rst_ni & (state_q == S_FETCH) & mem_ready_i;
    assign pc_write_o = rst_ni & (((state_q == S_FETCH) & mem_ready_i)
                                  | (state_q == S_JAL)
                                  | (state_q == S_JALR)
                                  | ((state_q == S_BRANCH) & taken));

    assign mem_write_o  = ctrl_q.mem_write;
    assign adr_src_o    = ctrl_q.adr_src;
    assign reg_write_o  = ctrl_q.reg_write;
    assign branch_o     = ctrl_q.branch;
    assign alu_src_a_o  = ctrl_q.src_a;
    assign alu_src_b_o  = ctrl_q.src_b;
    assign alu_op_o     = ctrl_q.alu_op;
    assign result_src_o = ctrl_q.result_src;
    assign illegal_o    = illegal_q;
    assign instret_o    = instret_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; a second 2-bit-counter instance shows counter wrap.
module tb_mc_control_fsm;
    import definitions_pkg::*;

    logic       clk;
    logic       rst_n;
    opcode_e    op;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       ready;

    logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic        branch_o, illegal_o;
    logic [31:0] instret_o;
    state_e      state_o;

    logic        s_mem_req, s_mem_write, s_adr_src, s_ir_write, s_pc_write, s_reg_write;
    logic [1:0]  s_src_a, s_src_b, s_alu_op, s_result_src;
    logic        s_branch, s_illegal;
    logic [1:0]  s_instret;
    state_e      s_state;

    int n_chk = 0;
    int n_bad = 0;

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(funct3), .zero_i(zero),
        .less_than_i(lt), .mem_ready_i(ready),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .result_src_o(result_src_o), .branch_o(branch_o), .illegal_o(illegal_o),
        .instret_o(instret_o), .state_o(state_o)
    );

    mc_control_fsm #(.CNT_W(2)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(funct3), .zero_i(zero),
        .less_than_i(lt), .mem_ready_i(ready),
        .mem_req_o(s_mem_req), .mem_write_o(s_mem_write), .adr_src_o(s_adr_src),
        .ir_write_o(s_ir_write), .pc_write_o(s_pc_write), .reg_write_o(s_reg_write),
        .alu_src_a_o(s_src_a), .alu_src_b_o(s_src_b), .alu_op_o(s_alu_op),
        .result_src_o(s_result_src), .branch_o(s_branch), .illegal_o(s_illegal),
        .instret_o(s_instret), .state_o(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input state_e exp);
        chk(tag, 32'(state_o), 32'(exp));
    endtask

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    // Branch: FETCH, DECODE, BRANCH, then back to FETCH with one more retirement.
    task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic l, input logic exp_taken, input int exp_cnt);
        op = OP_BRANCH; funct3 = f3; zero = z; lt = l; ready = 1'b1;
        nx(); chk_st({tag, "_dec"}, S_DECODE);
        nx(); chk_st({tag, "_st"}, S_BRANCH);
        chk({tag, "_br"}, 32'(branch_o), 32'd1);
        chk({tag, "_pcw"}, 32'(pc_write_o), 32'(exp_taken));
        chk({tag, "_aluop"}, 32'(alu_op_o), 32'd1);
        nx(); chk_st({tag, "_ret"}, S_FETCH);
        chk({tag, "_cnt"}, instret_o, 32'(exp_cnt));
        $display("%s retired taken=%0d instret=%0d", tag, pc_write_o, instret_o);
    endtask

    initial begin
        rst_n = 1'b0; op = OP_I; funct3 = 3'd0; zero = 1'b0; lt = 1'b0; ready = 1'b1;

        // Reset: FETCH selects visible, request/IR/PC strobes forced low.
        nx();
        chk_st("rst_state", S_FETCH);
        chk("rst_cnt", instret_o, 32'd0);
        chk("rst_ill", 32'(illegal_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_irw", 32'(ir_write_o), 32'd0);
        chk("rst_pcw", 32'(pc_write_o), 32'd0);
        chk("rst_srcb", 32'(alu_src_b_o), 32'd2);
        chk("rst_res", 32'(result_src_o), 32'd2);

        // addi
        rst_n = 1'b1; #1;
        chk("addi_req", 32'(mem_req_o), 32'd1);
        chk("addi_irw", 32'(ir_write_o), 32'd1);
        chk("addi_pcw", 32'(pc_write_o), 32'd1);
        nx(); chk_st("addi_dec", S_DECODE);
        chk("addi_dec_a", 32'(alu_src_a_o), 32'd1);
        chk("addi_dec_b", 32'(alu_src_b_o), 32'd1);
        chk("addi_dec_pcw", 32'(pc_write_o), 32'd0);
        nx(); chk_st("addi_ex", S_EXEC_I);
        chk("addi_ex_a", 32'(alu_src_a_o), 32'd2);
        chk("addi_ex_op", 32'(alu_op_o), 32'd2);
        nx(); chk_st("addi_wb", S_ALUWB);
        chk("addi_wb_rw", 32'(reg_write_o), 32'd1);
        chk("addi_wb_cnt", instret_o, 32'd0);
        nx(); chk_st("addi_ret", S_FETCH);
        chk("addi_cnt", instret_o, 32'd1);
        $display("addi retired instret=%0d", instret_o);

        // lw with two wait cycles in MEMREAD: 7 cycles total
        op = OP_LOAD;
        nx(); chk_st("lw_dec", S_DECODE);
        ready = 1'b0;
        nx(); chk_st("lw_adr", S_MEMADR);
        chk("lw_adr_a", 32'(alu_src_a_o), 32'd2);
        nx(); chk_st("lw_rd1", S_MEMREAD);
        chk("lw_rd_req", 32'(mem_req_o), 32'd1);
        chk("lw_rd_adr", 32'(adr_src_o), 32'd1);
        nx(); chk_st("lw_rd2", S_MEMREAD);
        nx(); chk_st("lw_rd3", S_MEMREAD);
        ready = 1'b1; #1;
        chk("lw_rd_pcw", 32'(pc_write_o), 32'd0);
        chk("lw_rd_irw", 32'(ir_write_o), 32'd0);
        nx(); chk_st("lw_wb", S_MEMWB);
        chk("lw_wb_res", 32'(result_src_o), 32'd1);
        chk("lw_wb_rw", 32'(reg_write_o), 32'd1);
        nx(); chk_st("lw_ret", S_FETCH);
        chk("lw_cnt", instret_o, 32'd2);
        $display("lw retired instret=%0d", instret_o);

        // FETCH wait state, then beq taken
        op = OP_BRANCH; ready = 1'b0; #1;
        chk("fw_irw", 32'(ir_write_o), 32'd0);
        chk("fw_pcw", 32'(pc_write_o), 32'd0);
        nx(); chk_st("fw_hold", S_FETCH);
        chk("fw_req", 32'(mem_req_o), 32'd1);
        do_branch("beq", 3'b000, 1'b1, 1'b0, 1'b1, 3);
        do_branch("bge", 3'b101, 1'b0, 1'b1, 1'b0, 4);
        chk("wrap_small", 32'(s_instret), 32'd0);
        do_branch("f3_010", 3'b010, 1'b1, 1'b1, 1'b0, 5);
        do_branch("blt", 3'b100, 1'b0, 1'b1, 1'b1, 6);

        // jalr
        op = OP_JALR;
        nx(); chk_st("jalr_dec", S_DECODE);
        nx(); chk_st("jalr_st", S_JALR);
        chk("jalr_pcw", 32'(pc_write_o), 32'd1);
        chk("jalr_res", 32'(result_src_o), 32'd2);
        nx(); chk_st("jalr_link", S_LINK);
        chk("link_rw", 32'(reg_write_o), 32'd1);
        chk("link_a", 32'(alu_src_a_o), 32'd1);
        chk("link_b", 32'(alu_src_b_o), 32'd2);
        nx(); chk_st("jalr_ret", S_FETCH);
        chk("jalr_cnt", instret_o, 32'd7);
        $display("jalr retired instret=%0d", instret_o);

        // lui
        op = OP_LUI;
        nx(); nx(); chk_st("lui_st", S_UPIMM);
        chk("lui_a", 32'(alu_src_a_o), 32'd3);
        nx(); chk_st("lui_wb", S_ALUWB);
        nx(); chk("lui_cnt", instret_o, 32'd8);
        $display("lui retired instret=%0d", instret_o);

        // auipc
        op = OP_AUIPC;
        nx(); nx(); chk("auipc_a", 32'(alu_src_a_o), 32'd1);
        nx(); nx(); chk("auipc_cnt", instret_o, 32'd9);
        $display("auipc retired instret=%0d", instret_o);

        // jal
        op = OP_JAL;
        nx(); nx(); chk_st("jal_st", S_JAL);
        chk("jal_pcw", 32'(pc_write_o), 32'd1);
        chk("jal_b", 32'(alu_src_b_o), 32'd2);
        nx(); chk_st("jal_wb", S_ALUWB);
        nx(); chk("jal_cnt", instret_o, 32'd10);
        chk("jal_small", 32'(s_instret), 32'd2);
        $display("jal retired instret=%0d", instret_o);

        // sw aborted by reset while waiting in MEMWRITE
        op = OP_STORE;
        nx(); ready = 1'b0;
        nx(); chk_st("sw_adr", S_MEMADR);
        nx(); chk_st("sw_wr", S_MEMWRITE);
        chk("sw_wr_we", 32'(mem_write_o), 32'd1);
        chk("sw_wr_req", 32'(mem_req_o), 32'd1);
        rst_n = 1'b0; ready = 1'b1; #1;
        chk_st("sw_rst_st", S_FETCH);
        chk("sw_rst_req", 32'(mem_req_o), 32'd0);
        chk("sw_rst_cnt", instret_o, 32'd0);
        nx(); chk("sw_rst_req2", 32'(mem_req_o), 32'd0);
        chk("sw_rst_pcw", 32'(pc_write_o), 32'd0);
        rst_n = 1'b1; #1;
        chk("sw_post_req", 32'(mem_req_o), 32'd1);
        $display("sw aborted by reset instret=%0d", instret_o);

        // illegal opcode traps and stays put
        op = opcode_e'(7'h7f);
        nx(); chk_st("trap_dec", S_DECODE);
        nx(); chk_st("trap_st", S_TRAP);
        chk("trap_ill", 32'(illegal_o), 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk_st("trap_hold", S_TRAP);
            chk("trap_strobes", {26'd0, mem_req_o, ir_write_o, pc_write_o, reg_write_o,
                                 mem_write_o, branch_o}, 32'd0);
            chk("trap_cnt", instret_o, 32'd0);
            chk("trap_ill_hold", 32'(illegal_o), 32'd1);
            nx();
        end
        $display("trap held illegal=%0d instret=%0d", illegal_o, instret_o);
        rst_n = 1'b0; #1;
        chk("trap_rst_ill", 32'(illegal_o), 32'd0);
        chk_st("trap_rst_st", S_FETCH);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
